// File: rtl/spike_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spike_scheduler: circular bank of per-tick axon rows for neuron_grid.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spike_scheduler #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_TICKS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         packet_valid,
    output logic                         packet_ready,
    input  logic [$clog2(NUM_AXONS)-1:0] packet_axon,
    input  logic [$clog2(NUM_TICKS)-1:0] packet_dt,
    input  logic                         scheduler_set,
    input  logic                         scheduler_clr,
    output logic [NUM_AXONS-1:0]         axon_spikes,
    output logic [$clog2(NUM_TICKS)-1:0] read_slot,
    output logic                         dt_error,
    output logic [15:0]                  drop_count
);

    localparam int TW = $clog2(NUM_TICKS);
    localparam logic [TW-1:0] DT_ILLEGAL = TW'(NUM_TICKS - 1);

    logic [NUM_AXONS-1:0] slot_q [NUM_TICKS];
    logic [NUM_AXONS-1:0] slot_d [NUM_TICKS];
    logic [TW-1:0]        read_ptr_q, read_ptr_d;
    logic                 dt_error_q, dt_error_d;
    logic [15:0]          drop_count_q, drop_count_d;
    logic [TW-1:0]        wr_slot;
    logic                 accept;
    logic                 dt_bad;

    always_comb begin
        packet_ready = rst & ~scheduler_set & ~scheduler_clr;
        accept       = packet_valid & packet_ready;
        dt_bad       = (packet_dt == DT_ILLEGAL);
        wr_slot      = read_ptr_q + TW'(1) + packet_dt;
        slot_d       = slot_q;
        read_ptr_d   = read_ptr_q;
        dt_error_d   = 1'b0;
        drop_count_d = drop_count_q;

        // Accept never coincides with set/clr, so the row write cannot collide with the clear.
        if (accept && !dt_bad) begin
            slot_d[wr_slot][packet_axon] = 1'b1;
        end
        if (accept && dt_bad) begin
            dt_error_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
        if (scheduler_clr) begin
            slot_d[read_ptr_q] = '0;
        end
        if (scheduler_set) begin
            read_ptr_d = read_ptr_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TICKS; i++) begin
                slot_q[i] <= '0;
            end
            read_ptr_q   <= '0;
            dt_error_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_TICKS; i++) begin
                slot_q[i] <= slot_d[i];
            end
            read_ptr_q   <= read_ptr_d;
            dt_error_q   <= dt_error_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign axon_spikes = slot_q[read_ptr_q];
    assign read_slot   = read_ptr_q;
    assign dt_error    = dt_error_q;
    assign drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spike_scheduler: directed vector table plus hand-written corner sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spike_scheduler;

    localparam int NA = 256;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          packet_valid;
    logic          packet_ready;
    logic [7:0]    packet_axon;
    logic [3:0]    packet_dt;
    logic          scheduler_set;
    logic          scheduler_clr;
    logic [NA-1:0] axon_spikes;
    logic [3:0]    read_slot;
    logic          dt_error;
    logic [15:0]   drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    spike_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT)) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .packet_axon  (packet_axon),
        .packet_dt    (packet_dt),
        .scheduler_set(scheduler_set),
        .scheduler_clr(scheduler_clr),
        .axon_spikes  (axon_spikes),
        .read_slot    (read_slot),
        .dt_error     (dt_error),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [7:0]    axon;
        logic [3:0]    dt;
        logic          set;
        logic          clr;
        logic          rdy;
        logic [NA-1:0] sp;
        logic [3:0]    slot;
        logic          err;
        logic [15:0]   drop;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [NA-1:0] oh(input int n);
        logic [NA-1:0] r;
        r    = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    function automatic void add(input logic v, input int axon, input int dt,
                                input logic set, input logic clr, input logic rdy,
                                input logic [NA-1:0] sp, input int slot,
                                input logic err, input int drop);
        vec_t t;
        t.v    = v;
        t.axon = 8'(axon);
        t.dt   = 4'(dt);
        t.set  = set;
        t.clr  = clr;
        t.rdy  = rdy;
        t.sp   = sp;
        t.slot = 4'(slot);
        t.err  = err;
        t.drop = 16'(drop);
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [NA-1:0] act, input logic [NA-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int axon, input int dt, input logic set, input logic clr);
        packet_valid  = v;
        packet_axon   = 8'(axon);
        packet_dt     = 4'(dt);
        scheduler_set = set;
        scheduler_clr = clr;
    endtask

    task automatic check_out(input string tag, input logic [NA-1:0] sp, input int slot,
                             input logic err, input int drop);
        chk({tag, " spikes"}, axon_spikes, sp);
        chk({tag, " slot"}, NA'(read_slot), NA'(slot));
        chk({tag, " dt_error"}, NA'(dt_error), NA'(err));
        chk({tag, " drop"}, NA'(drop_count), NA'(drop));
    endtask

    initial begin
        // Vector table: state tracked by hand from reset (ptr 0, all rows empty).
        add(1, 5, 0, 0, 0, 1, '0,     0, 0, 0);   // axon5 -> slot1
        add(0, 0, 0, 1, 0, 0, oh(5),  1, 0, 0);
        add(0, 0, 0, 0, 1, 0, '0,     1, 0, 0);
        add(1, 3, 2, 0, 0, 1, '0,     1, 0, 0);   // axon3 -> slot4
        add(1, 3, 2, 0, 0, 1, '0,     1, 0, 0);   // duplicate, no error
        add(0, 0, 0, 1, 0, 0, '0,     2, 0, 0);
        add(0, 0, 0, 1, 0, 0, '0,     3, 0, 0);
        add(0, 0, 0, 1, 0, 0, oh(3),  4, 0, 0);
        add(0, 0, 0, 0, 1, 0, '0,     4, 0, 0);
        add(1, 7, 15, 0, 0, 1, '0,    4, 1, 1);   // illegal delay dropped
        add(0, 0, 0, 0, 0, 1, '0,     4, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            add(0, 0, 0, 1, 0, 0, '0, (4 + i) % 16, 0, 1);
        end
        add(1, 20, 0, 1, 0, 0, '0,    5, 0, 1);   // offered during set: refused
        add(0, 0, 0, 0, 0, 1, '0,     5, 0, 1);
        for (int p = 6; p <= 14; p++) begin
            add(0, 0, 0, 1, 0, 0, '0, p, 0, 1);
        end
        add(1, 0, 3, 0, 0, 1, '0,     14, 0, 1);  // wraps to slot2
        add(0, 0, 0, 1, 0, 0, '0,     15, 0, 1);
        add(0, 0, 0, 1, 0, 0, '0,     0, 0, 1);
        add(0, 0, 0, 1, 0, 0, '0,     1, 0, 1);
        add(0, 0, 0, 1, 0, 0, oh(0),  2, 0, 1);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        chk("reset ready", NA'(packet_ready), '0);
        check_out("reset", '0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, int'(tbl[i].axon), int'(tbl[i].dt), tbl[i].set, tbl[i].clr);
            #1;
            chk($sformatf("vec%0d ready", i), NA'(packet_ready), NA'(tbl[i].rdy));
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].sp, int'(tbl[i].slot), tbl[i].err, int'(tbl[i].drop));
        end

        // Simultaneous set+clr with a held packet (ptr 2, slot2 holds axon0).
        drive(1, 9, 0, 0, 0);                      // axon9 -> slot3
        @(posedge clk);
        #1;
        drive(1, 12, 0, 1, 1);
        #1;
        chk("setclr ready", NA'(packet_ready), '0);
        @(posedge clk);
        #1;
        check_out("setclr", oh(9), 3, 0, 1);
        drive(1, 12, 0, 0, 0);
        #1;
        chk("after setclr ready", NA'(packet_ready), NA'(1));
        @(posedge clk);
        #1;
        check_out("held accept", oh(9), 3, 0, 1);
        drive(0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check_out("held visible", oh(12), 4, 0, 1);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("walk%0d", i), '0, (4 + i) % 16, 0, 1);
        end

        // Reset in the middle of a burst.
        drive(1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 2, 5, 0, 0);
        @(posedge clk);
        #1;
        drive(1, 3, 15, 0, 0);
        @(posedge clk);
        #1;
        check_out("burst", '0, 2, 1, 2);
        drive(1, 4, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async ready", NA'(packet_ready), '0);
        check_out("async reset", '0, 0, 0, 0);
        @(posedge clk);
        #4;
        rst = 1'b1;
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check_out($sformatf("post reset%0d", i), '0, i % 16, 0, 0);
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("post reset ready", NA'(packet_ready), NA'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
